// File: rtl/msrv32_dmem_responder.sv
// Data-memory responder: byte-masked word array behind a ready handshake
// with a programmable number of wait states per transfer.
module msrv32_dmem_responder #(
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_STATES = 1
) (
   input  logic        ms_riscv32_mp_clk_in,
   input  logic        ms_riscv32_mp_rst_n_in,
   input  logic [31:0] ms_riscv32_mp_dmaddr_in,
   input  logic [31:0] ms_riscv32_mp_dmdata_in,
   input  logic [3:0]  ms_riscv32_mp_dmwr_mask_in,
   input  logic        ms_riscv32_mp_dmwr_req_in,
   input  logic        ms_riscv32_mp_dmrd_req_in,
   output logic        ahb_ready_out,
   output logic [31:0] ms_riscv32_mp_dmrdata_out,
   output logic        dm_err_out
);

   localparam int unsigned LP_DEPTH    = 2**ADDR_WIDTH;
   localparam logic [3:0]  LP_CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

   typedef enum logic {
      S_IDLE,
      S_WAIT
   } state_t;

   state_t                r_state, w_state_n;
   logic [3:0]            r_cnt, w_cnt_n;
   logic [ADDR_WIDTH-1:0] r_word;
   logic [31:0]           r_data;
   logic [3:0]            r_mask;
   logic                  r_is_wr;
   logic                  r_oor;
   logic [31:0]           r_rdata;
   logic                  r_err;
   logic [31:0]           r_mem [LP_DEPTH];

   logic                  w_accept;
   logic                  w_fire;
   logic [ADDR_WIDTH-1:0] w_in_word;
   logic                  w_in_oor;
   logic [ADDR_WIDTH-1:0] w_sel_word;
   logic [31:0]           w_sel_data;
   logic [3:0]            w_sel_mask;
   logic                  w_sel_wr;
   logic                  w_sel_oor;
   logic                  w_unused_addr_lsb;

   assign w_unused_addr_lsb = ^ms_riscv32_mp_dmaddr_in[1:0];
   assign w_in_word         = ms_riscv32_mp_dmaddr_in[ADDR_WIDTH+1:2];
   assign w_in_oor          = |ms_riscv32_mp_dmaddr_in[31:ADDR_WIDTH+2];
   assign w_accept          = (r_state == S_IDLE) &&
                              (ms_riscv32_mp_dmwr_req_in || ms_riscv32_mp_dmrd_req_in);

   // With no wait states the access uses the live request on its accept edge;
   // otherwise it uses the payload latched at accept time.
   always_comb begin
      if (WAIT_STATES == 0) begin
         w_fire     = w_accept;
         w_sel_word = w_in_word;
         w_sel_data = ms_riscv32_mp_dmdata_in;
         w_sel_mask = ms_riscv32_mp_dmwr_mask_in;
         w_sel_wr   = ms_riscv32_mp_dmwr_req_in;
         w_sel_oor  = w_in_oor;
      end else begin
         w_fire     = (r_state == S_WAIT) && (r_cnt == 4'd0);
         w_sel_word = r_word;
         w_sel_data = r_data;
         w_sel_mask = r_mask;
         w_sel_wr   = r_is_wr;
         w_sel_oor  = r_oor;
      end
   end

   always_comb begin
      w_state_n = r_state;
      w_cnt_n   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_accept && (WAIT_STATES != 0)) begin
               w_state_n = S_WAIT;
               w_cnt_n   = LP_CNT_INIT;
            end
         end
         S_WAIT: begin
            if (r_cnt == 4'd0) w_state_n = S_IDLE;
            else               w_cnt_n   = r_cnt - 4'd1;
         end
         default: w_state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
      if (!ms_riscv32_mp_rst_n_in) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_word  <= '0;
         r_data  <= '0;
         r_mask  <= '0;
         r_is_wr <= 1'b0;
         r_oor   <= 1'b0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_cnt   <= w_cnt_n;
         if (w_accept) begin
            r_word  <= w_in_word;
            r_data  <= ms_riscv32_mp_dmdata_in;
            r_mask  <= ms_riscv32_mp_dmwr_mask_in;
            r_is_wr <= ms_riscv32_mp_dmwr_req_in;
            r_oor   <= w_in_oor;
         end
         if (w_fire && !w_sel_wr)
            r_rdata <= w_sel_oor ? '0 : r_mem[w_sel_word];
         r_err <= w_fire && w_sel_oor;
      end
   end

   // Array contents survive reset; the rst_n gate keeps a held-in-reset edge from writing.
   always_ff @(posedge ms_riscv32_mp_clk_in) begin
      if (ms_riscv32_mp_rst_n_in && w_fire && w_sel_wr && !w_sel_oor) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (w_sel_mask[b])
               r_mem[w_sel_word][8*b +: 8] <= w_sel_data[8*b +: 8];
         end
      end
   end

   assign ahb_ready_out             = (r_state == S_IDLE);
   assign ms_riscv32_mp_dmrdata_out = r_rdata;
   assign dm_err_out                = r_err;

endmodule

// File: tb/tb_msrv32_dmem_responder.sv
// Directed bench: three responders (1, 3 and 0 wait states) driven by
// per-scenario tasks with hand-computed expectations.
module tb_msrv32_dmem_responder;

   logic        clk = 1'b0;
   logic        rst_n [3];
   logic [31:0] addr  [3];
   logic [31:0] wdata [3];
   logic [3:0]  mask  [3];
   logic        wr    [3];
   logic        rd    [3];
   logic        ready [3];
   logic [31:0] rdata [3];
   logic        err   [3];

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   msrv32_dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(1)) u_ws1 (
      .ms_riscv32_mp_clk_in       (clk),
      .ms_riscv32_mp_rst_n_in     (rst_n[0]),
      .ms_riscv32_mp_dmaddr_in    (addr[0]),
      .ms_riscv32_mp_dmdata_in    (wdata[0]),
      .ms_riscv32_mp_dmwr_mask_in (mask[0]),
      .ms_riscv32_mp_dmwr_req_in  (wr[0]),
      .ms_riscv32_mp_dmrd_req_in  (rd[0]),
      .ahb_ready_out              (ready[0]),
      .ms_riscv32_mp_dmrdata_out  (rdata[0]),
      .dm_err_out                 (err[0])
   );

   msrv32_dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(3)) u_ws3 (
      .ms_riscv32_mp_clk_in       (clk),
      .ms_riscv32_mp_rst_n_in     (rst_n[1]),
      .ms_riscv32_mp_dmaddr_in    (addr[1]),
      .ms_riscv32_mp_dmdata_in    (wdata[1]),
      .ms_riscv32_mp_dmwr_mask_in (mask[1]),
      .ms_riscv32_mp_dmwr_req_in  (wr[1]),
      .ms_riscv32_mp_dmrd_req_in  (rd[1]),
      .ahb_ready_out              (ready[1]),
      .ms_riscv32_mp_dmrdata_out  (rdata[1]),
      .dm_err_out                 (err[1])
   );

   msrv32_dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_ws0 (
      .ms_riscv32_mp_clk_in       (clk),
      .ms_riscv32_mp_rst_n_in     (rst_n[2]),
      .ms_riscv32_mp_dmaddr_in    (addr[2]),
      .ms_riscv32_mp_dmdata_in    (wdata[2]),
      .ms_riscv32_mp_dmwr_mask_in (mask[2]),
      .ms_riscv32_mp_dmwr_req_in  (wr[2]),
      .ms_riscv32_mp_dmrd_req_in  (rd[2]),
      .ahb_ready_out              (ready[2]),
      .ms_riscv32_mp_dmrdata_out  (rdata[2]),
      .dm_err_out                 (err[2])
   );

   // One transfer; returns at the negedge where ready is back high.
   task automatic xfer(input int k, input logic w, input logic r, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] m, output int waits);
      @(negedge clk);
      addr[k] = a; wdata[k] = d; mask[k] = m; wr[k] = w; rd[k] = r;
      @(posedge clk);
      @(negedge clk);
      wr[k] = 1'b0; rd[k] = 1'b0;
      waits = 0;
      while (ready[k] !== 1'b1 && waits < 40) begin
         waits++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      #2;
      for (int k = 0; k < 3; k++) begin
         checks++; if (ready[k] !== 1'b1) $display("FAIL reset_ready[%0d] got=%b exp=1", k, ready[k]); else passes++;
         checks++; if (rdata[k] !== 32'h0) $display("FAIL reset_rdata[%0d] got=%h exp=0", k, rdata[k]); else passes++;
         checks++; if (err[k] !== 1'b0) $display("FAIL reset_err[%0d] got=%b exp=0", k, err[k]); else passes++;
      end
      #10;
      @(negedge clk);
      for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
   endtask

   task automatic test_basic();
      int w;
      xfer(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 4'b1111, w);
      checks++; if (w !== 1) $display("FAIL basic_wr_waits got=%0d exp=1", w); else passes++;
      xfer(0, 1'b0, 1'b1, 32'h10, 32'h0, 4'b0000, w);
      checks++; if (w !== 1) $display("FAIL basic_rd_waits got=%0d exp=1", w); else passes++;
      checks++; if (rdata[0] !== 32'hDEADBEEF) $display("FAIL basic_rdata got=%h exp=deadbeef", rdata[0]); else passes++;
      checks++; if (err[0] !== 1'b0) $display("FAIL basic_err got=%b exp=0", err[0]); else passes++;
   endtask

   task automatic test_byte_lanes();
      int w;
      xfer(0, 1'b1, 1'b0, 32'h20, 32'h11223344, 4'b1111, w);
      xfer(0, 1'b1, 1'b0, 32'h20, 32'h0000AB00, 4'b0010, w);
      xfer(0, 1'b0, 1'b1, 32'h20, 32'h0, 4'b0000, w);
      checks++; if (rdata[0] !== 32'h1122AB44) $display("FAIL lane_m0010 got=%h exp=1122ab44", rdata[0]); else passes++;
      xfer(0, 1'b1, 1'b0, 32'h20, 32'hCDEF0000, 4'b1100, w);
      xfer(0, 1'b0, 1'b1, 32'h20, 32'h0, 4'b0000, w);
      checks++; if (rdata[0] !== 32'hCDEFAB44) $display("FAIL lane_m1100 got=%h exp=cdefab44", rdata[0]); else passes++;
      xfer(0, 1'b1, 1'b0, 32'h20, 32'hFFFFFFFF, 4'b0000, w);
      checks++; if (w !== 1) $display("FAIL lane_m0000_waits got=%0d exp=1", w); else passes++;
      xfer(0, 1'b0, 1'b1, 32'h20, 32'h0, 4'b0000, w);
      checks++; if (rdata[0] !== 32'hCDEFAB44) $display("FAIL lane_m0000 got=%h exp=cdefab44", rdata[0]); else passes++;
   endtask

   task automatic test_priority();
      int w;
      xfer(0, 1'b1, 1'b1, 32'h23, 32'h55AA55AA, 4'b1111, w);
      checks++; if (rdata[0] !== 32'hCDEFAB44) $display("FAIL prio_rdata_held got=%h exp=cdefab44", rdata[0]); else passes++;
      xfer(0, 1'b0, 1'b1, 32'h21, 32'h0, 4'b0000, w);
      checks++; if (rdata[0] !== 32'h55AA55AA) $display("FAIL prio_readback got=%h exp=55aa55aa", rdata[0]); else passes++;
   endtask

   task automatic test_out_of_range();
      int w;
      xfer(0, 1'b1, 1'b0, 32'h0, 32'h0BADF00D, 4'b1111, w);
      xfer(0, 1'b0, 1'b1, 32'h1000, 32'h0, 4'b0000, w);
      checks++; if (rdata[0] !== 32'h0) $display("FAIL oor_rdata got=%h exp=0", rdata[0]); else passes++;
      checks++; if (err[0] !== 1'b1) $display("FAIL oor_rd_err got=%b exp=1", err[0]); else passes++;
      @(negedge clk);
      checks++; if (err[0] !== 1'b0) $display("FAIL oor_err_pulse got=%b exp=0", err[0]); else passes++;
      xfer(0, 1'b1, 1'b0, 32'h1000, 32'hFFFFFFFF, 4'b1111, w);
      checks++; if (err[0] !== 1'b1) $display("FAIL oor_wr_err got=%b exp=1", err[0]); else passes++;
      xfer(0, 1'b0, 1'b1, 32'h0, 32'h0, 4'b0000, w);
      checks++; if (rdata[0] !== 32'h0BADF00D) $display("FAIL oor_wr_suppressed got=%h exp=0badf00d", rdata[0]); else passes++;
      checks++; if (err[0] !== 1'b0) $display("FAIL oor_inrange_err got=%b exp=0", err[0]); else passes++;
   endtask

   task automatic test_wait3();
      int w;
      xfer(1, 1'b1, 1'b0, 32'h80, 32'hCAFE0001, 4'b1111, w);
      checks++; if (w !== 3) $display("FAIL ws3_wr_waits got=%0d exp=3", w); else passes++;
      @(negedge clk);
      addr[1] = 32'h80; rd[1] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      w = 0;
      while (ready[1] !== 1'b1 && w < 40) begin
         rd[1] = ~rd[1];
         addr[1] = 32'h84;
         w++;
         @(negedge clk);
      end
      rd[1] = 1'b0;
      checks++; if (w !== 3) $display("FAIL ws3_rd_waits got=%0d exp=3", w); else passes++;
      checks++; if (rdata[1] !== 32'hCAFE0001) $display("FAIL ws3_rdata got=%h exp=cafe0001", rdata[1]); else passes++;
      @(negedge clk);
      checks++; if (ready[1] !== 1'b1) $display("FAIL ws3_toggle_ignored got=%b exp=1", ready[1]); else passes++;
   endtask

   task automatic test_reset_mid_wait();
      int w;
      xfer(1, 1'b1, 1'b0, 32'h40, 32'h12345678, 4'b1111, w);
      xfer(1, 1'b0, 1'b1, 32'h40, 32'h0, 4'b0000, w);
      checks++; if (rdata[1] !== 32'h12345678) $display("FAIL rstw_pre got=%h exp=12345678", rdata[1]); else passes++;
      @(negedge clk);
      addr[1] = 32'h40; wdata[1] = 32'hFFFFFFFF; mask[1] = 4'b1111; wr[1] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      wr[1] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n[1] = 1'b0;
      #1;
      checks++; if (ready[1] !== 1'b1) $display("FAIL rstw_ready got=%b exp=1", ready[1]); else passes++;
      checks++; if (rdata[1] !== 32'h0) $display("FAIL rstw_rdata got=%h exp=0", rdata[1]); else passes++;
      @(negedge clk);
      rst_n[1] = 1'b1;
      xfer(1, 1'b0, 1'b1, 32'h40, 32'h0, 4'b0000, w);
      checks++; if (w !== 3) $display("FAIL rstw_rd_waits got=%0d exp=3", w); else passes++;
      checks++; if (rdata[1] !== 32'h12345678) $display("FAIL rstw_no_write got=%h exp=12345678", rdata[1]); else passes++;
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++; if (ready[2] !== 1'b1) $display("FAIL b2b_wr_ready[%0d] got=%b exp=1", i, ready[2]); else passes++;
         addr[2] = 32'h100 + 32'(4*i); wdata[2] = 32'hA0000000 + 32'(i);
         mask[2] = 4'b1111; wr[2] = 1'b1; rd[2] = 1'b0;
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++; if (ready[2] !== 1'b1) $display("FAIL b2b_rd_ready[%0d] got=%b exp=1", i, ready[2]); else passes++;
         if (i > 0) begin
            checks++;
            if (rdata[2] !== 32'hA0000000 + 32'(i-1))
               $display("FAIL b2b_rdata[%0d] got=%h exp=%h", i-1, rdata[2], 32'hA0000000 + 32'(i-1));
            else passes++;
         end
         addr[2] = 32'h100 + 32'(4*i); wr[2] = 1'b0; rd[2] = 1'b1;
      end
      @(negedge clk);
      rd[2] = 1'b0;
      checks++; if (rdata[2] !== 32'hA0000003) $display("FAIL b2b_rdata[3] got=%h exp=a0000003", rdata[2]); else passes++;
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin
         rst_n[k] = 1'b0; addr[k] = '0; wdata[k] = '0; mask[k] = '0; wr[k] = 1'b0; rd[k] = 1'b0;
      end
      test_reset();
      test_basic();
      test_byte_lanes();
      test_priority();
      test_out_of_range();
      test_wait3();
      test_reset_mid_wait();
      test_back_to_back();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
